neural_navigators: RTL and testbench
====================================

# neural_navigators

Tiny fixed-function neural inference tile: four binary-input perceptrons that map an 8-bit sensor vector to fire flags and a winning-neuron index, intended as a steering/decision core for a small navigation agent. Weights and biases are loaded through a byte-wide configuration port. The block sits directly behind the standard tile pin interface, and every pin it uses is a top-level tile pin.

## Interface
- Parameters: none.
- `clk`: input, 1 bit. Single clock, rising edge.
- `rst_n`: input, 1 bit. Reset, asynchronous and active-low.
- `ena`: input, 1 bit. Tile enable. While 0, all state holds.
- `ui_in`: input, 8 bits. Sensor vector during inference. Configuration data during a write.
- `uio_in`: input, 8 bits.
  - [7] is `cfg_we`.
  - [6] is `rb_sel`; it is used only when NEURAL_NAV_READBACK_EN is defined.
  - [5:0] is the configuration address.
- `uo_out`: output, 8 bits.
  - [3:0] are the fire flags, one per neuron.
  - [5:4] is the argmax index.
  - [6] is `valid`.
  - [7] is `any_fire`.
- `uio_out`: output, 8 bits. Tied to 0.
- `uio_oe`: output, 8 bits. Tied to 0, so all uio pins are inputs.

## Operation
- State:
  - w[n][i]: 4-bit signed weight, for n in 0..3 and i in 0..7 (32 weights).
  - b[n]: 8-bit signed bias, n in 0..3.
  - Output register: 8 bits.
- Write cycle (`ena`=1, `cfg_we`=1):
  - Addresses 0..31 write w[addr[4:3]][addr[2:0]] <= ui_in[3:0]; ui_in[7:4] is ignored.
  - Addresses 32..35 write b[addr[1:0]] <= ui_in.
  - Addresses 36..63 are ignored and have no effect.
  - Output register: fire flags, argmax and `any_fire` hold. `valid` is cleared to 0.
- Inference cycle (`ena`=1, `cfg_we`=0):
  - Compute, per neuron: s[n] = b[n] + sum of w[n][i] over every i with ui_in[i]=1.
  - Arithmetic is 9-bit signed with all operands sign-extended. The range is -192..183, so no overflow occurs.
  - fire[n] = (s[n] > 0). A sum of exactly 0 does not fire.
  - argmax = index of the maximum s[n]. On a tie, the lowest index wins.
  - `any_fire` = OR of fire[3:0]. `valid` = 1.
  - All of these are registered into uo_out.
- Simultaneous write and inference cannot occur; `cfg_we` selects exactly one.
- Weights written in cycle k affect the first inference cycle after k.

## Timing
- Reset (`rst_n`=0), applied asynchronously:
  - All weights and biases become 0.
  - uo_out = 0x00.
  - uio_out = 0x00 and uio_oe = 0x00 at all times.
- Inference latency is 1 clock: ui_in sampled at edge k appears on uo_out after edge k.
  - A new result is produced every cycle, fully pipelined, with no handshake.
- Writes take effect at the sampling edge. A write-then-infer pair on back-to-back edges must use the new value.
- `ena`=0: nothing updates (weights, biases, uo_out).
- Reset mid-stream: the asynchronous clear above applies immediately. After release, the first inference uses all-zero parameters: all s=0, no fire, argmax=0, so uo_out=0x40.

## Configuration
- Macro: NEURAL_NAV_READBACK_EN.
- Defined: on an inference cycle with `rb_sel`=1, uo_out instead registers s[addr[1:0]] saturated to signed 8 bits, clamped to the range -128..127.
  - `valid` semantics do not apply on such a cycle.
  - Write cycles are unaffected.
- Undefined: `rb_sel` is ignored and the block behaves exactly as in Operation.

## Test plan
- Reset: hold `rst_n`=0 with `clk` toggling. Required: uo_out=0x00, uio_oe=0x00. Release, then apply ui_in=0xFF with `cfg_we`=0. Required: uo_out=0x40 after one edge.
- Single neuron fires:
  - Writes: w[0][0]=+3 (uio_in=0x80, ui_in=0x03), then b[0]=-2 (uio_in=0xA0, ui_in=0xFE).
  - Infer ui_in=0x01. Required: uo_out=0xC1 (s0=1).
- Negative winner exclusion: with the same setup, infer ui_in=0x00. Required: s0=-2 and s1..s3=0, so uo_out=0x50 (no fire, argmax=1).
- Argmax and ties:
  - Writes: b[2]=5 (uio_in=0xA2, ui_in=0x05), b[3]=5 (uio_in=0xA3, ui_in=0x05).
  - Infer ui_in=0x00. Required: fire=0b1100 and argmax=2, so uo_out=0xEC.
- Saturation extremes:
  - Writes: all w[1][i]=-8 and b[1]=-128.
  - Infer ui_in=0xFF. Required: s1=-192 with no wrap, fire[1]=0. With the readback macro defined and `rb_sel`=1, addr=1: uo_out=0x80.
- Write/hold and enable:
  - A write cycle must leave uo_out[5:0] and [7] unchanged and set [6]=0.
  - With `ena`=0, changing ui_in and uio_in must change neither uo_out nor any weight.

Source files
------------

// File: rtl/neural_navigators_if.sv
// -----------------------------------------------------------------------------
// neural_navigators_if
// Tile pin bundle for the neural_navigators inference tile.
//   ena     : tile enable (driven by master)
//   ui_in   : sensor vector / configuration data (driven by master)
//   uio_in  : [7] cfg_we, [6] rb_sel, [5:0] configuration address (master)
//   uo_out  : [3:0] fire, [5:4] argmax, [6] valid, [7] any_fire (slave)
//   uio_out : unused output pins, always zero (slave)
//   uio_oe  : output enables, always zero so uio pins are inputs (slave)
// -----------------------------------------------------------------------------
interface neural_navigators_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena,
        output ui_in,
        output uio_in,
        input  uo_out,
        input  uio_out,
        input  uio_oe
    );

    modport slave (
        input  ena,
        input  ui_in,
        input  uio_in,
        output uo_out,
        output uio_out,
        output uio_oe
    );
endinterface

// File: rtl/neural_navigators.sv
// -----------------------------------------------------------------------------
// neural_navigators
// Four binary-input perceptrons. Each neuron adds its 4-bit signed weights for
// every set sensor bit to an 8-bit signed bias; the 9-bit sums produce fire
// flags (sum > 0), an argmax index (lowest index wins ties) and any_fire, all
// registered onto uo_out with one cycle of latency. Weights and biases are
// written through a byte-wide configuration port sharing the sensor pins.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears parameters and uo_out
//   tile  : neural_navigators_if.slave pin bundle (ena, ui_in, uio_in,
//           uo_out, uio_out, uio_oe)
//
// Optional feature macro: NEURAL_NAV_READBACK_EN
//   When defined, an inference cycle with rb_sel=1 registers the sum of
//   neuron addr[1:0], saturated to signed 8 bits, onto uo_out instead of the
//   normal decision byte. When undefined, rb_sel is ignored.
// -----------------------------------------------------------------------------
module neural_navigators (
    input  logic                       clk,
    input  logic                       rst_n,
    neural_navigators_if.slave         tile
);

    // Clamp a 9-bit signed sum into the signed 8-bit range.
    function automatic logic [7:0] sat8(input logic signed [8:0] v);
        logic [7:0] r;
        if (v > 9'sd127) begin
            r = 8'h7F;
        end else if (v < -9'sd128) begin
            r = 8'h80;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    // Bias plus the sign-extended weight of every active sensor bit.
    function automatic logic signed [8:0] neuron_sum(
        input logic [7:0]      bias,
        input logic [7:0][3:0] wrow,
        input logic [7:0]      x
    );
        logic signed [8:0] acc;
        acc = {bias[7], bias};
        for (int i = 0; i < 8; i++) begin
            if (x[i]) begin
                acc = acc + {{5{wrow[i][3]}}, wrow[i]};
            end else begin
                acc = acc;
            end
        end
        return acc;
    endfunction

    // Parameter and output state
    logic [3:0][7:0][3:0] w_q;
    logic [3:0][7:0][3:0] w_d;
    logic [3:0][7:0]      b_q;
    logic [3:0][7:0]      b_d;
    logic [7:0]           out_q;
    logic [7:0]           out_d;

    // Decoded pin fields
    logic       cfg_we_s;
    logic       rb_sel_s;
    logic [5:0] addr_s;

    // Datapath
    logic signed [8:0] sum_s [4];
    logic [3:0]        fire_s;
    logic [1:0]        argmax_s;
    logic signed [8:0] best_s;
    logic [7:0]        infer_byte_s;

    assign cfg_we_s = tile.uio_in[7];
    assign rb_sel_s = tile.uio_in[6];
    assign addr_s   = tile.uio_in[5:0];

`ifndef NEURAL_NAV_READBACK_EN
    // rb_sel has no function in this build.
    logic unused_rb_sel_s;
    assign unused_rb_sel_s = rb_sel_s;
`endif

    // Per-neuron sums and fire flags from the current parameters and sensors.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            sum_s[n]  = neuron_sum(b_q[n], w_q[n], tile.ui_in);
            fire_s[n] = (sum_s[n] > 9'sd0);
        end
    end

    // Argmax scan; strict comparison keeps the lowest index on ties.
    always_comb begin
        best_s   = sum_s[0];
        argmax_s = 2'd0;
        for (int n = 1; n < 4; n++) begin
            if (sum_s[n] > best_s) begin
                best_s   = sum_s[n];
                argmax_s = 2'(n);
            end else begin
                best_s   = best_s;
                argmax_s = argmax_s;
            end
        end
    end

    // Decision byte: any_fire, valid, argmax, fire flags.
    always_comb begin
        infer_byte_s = {(|fire_s), 1'b1, argmax_s, fire_s};
    end

    // Next-state: configuration writes, inference results, enable hold.
    always_comb begin
        w_d   = w_q;
        b_d   = b_q;
        out_d = out_q;
        if (tile.ena) begin
            if (cfg_we_s) begin
                case (addr_s[5])
                    1'b0: begin
                        w_d[addr_s[4:3]][addr_s[2:0]] = tile.ui_in[3:0];
                    end
                    1'b1: begin
                        // Only 32..35 map to biases; 36..63 are holes.
                        if (addr_s[4:2] == 3'b000) begin
                            b_d[addr_s[1:0]] = tile.ui_in;
                        end else begin
                            b_d = b_q;
                        end
                    end
                    default: begin
                        w_d = w_q;
                    end
                endcase
                // A write keeps the last decision but marks it stale.
                out_d = {out_q[7], 1'b0, out_q[5:0]};
            end else begin
`ifdef NEURAL_NAV_READBACK_EN
                if (rb_sel_s) begin
                    out_d = sat8(sum_s[addr_s[1:0]]);
                end else begin
                    out_d = infer_byte_s;
                end
`else
                out_d = infer_byte_s;
`endif
            end
        end else begin
            out_d = out_q;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= '0;
            b_q   <= '0;
            out_q <= 8'h00;
        end else begin
            w_q   <= w_d;
            b_q   <= b_d;
            out_q <= out_d;
        end
    end

    assign tile.uo_out  = out_q;
    assign tile.uio_out = 8'h00;
    assign tile.uio_oe  = 8'h00;

endmodule

// File: tb/tb_neural_navigators.sv
// -----------------------------------------------------------------------------
// tb_neural_navigators
// Scoreboard bench for neural_navigators: each driven cycle pushes the byte a
// small behavioural model predicts for uo_out; the byte is popped and compared
// one edge later. Test-plan values are also checked against fixed constants.
// -----------------------------------------------------------------------------
module tb_neural_navigators;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    neural_navigators_if tile_if ();

    neural_navigators dut (
        .clk   (clk),
        .rst_n (rst_n),
        .tile  (tile_if)
    );

    always #5 clk = ~clk;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         mw [4][8];
    int         mb [4];
    logic [7:0] m_out;
    logic [7:0] exp_q [$];
    logic [7:0] last_out;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected 0x%02h", tag, obs, exp_v);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 4; n++) begin
            mb[n] = 0;
            for (int i = 0; i < 8; i++) mw[n][i] = 0;
        end
        m_out = 8'h00;
    endtask

    task automatic model_infer(input logic [7:0] x, input logic rb, input logic [1:0] a);
        int         s [4];
        int         idx;
        logic [3:0] f;
        logic [1:0] idx2;
        for (int n = 0; n < 4; n++) begin
            s[n] = mb[n];
            for (int i = 0; i < 8; i++) if (x[i]) s[n] = s[n] + mw[n][i];
            f[n] = (s[n] > 0);
        end
        idx = 0;
        for (int n = 1; n < 4; n++) if (s[n] > s[idx]) idx = n;
        idx2  = idx[1:0];
        m_out = {(f != 4'b0000), 1'b1, idx2, f};
`ifdef NEURAL_NAV_READBACK_EN
        if (rb) begin
            int v;
            v = s[a];
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            m_out = v[7:0];
        end
`endif
    endtask

    // Advance one edge and compare uo_out with the oldest predicted byte.
    task automatic step(input string tag);
        logic [7:0] e;
        @(posedge clk);
        #1;
        last_out = tile_if.uo_out;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: got 0x%02h, expected nothing queued", tag, last_out);
        end else begin
            e = exp_q.pop_front();
            check_val(tag, last_out, e);
        end
    endtask

    task automatic do_write(input logic [5:0] addr, input logic [7:0] data, input string tag);
        logic signed [3:0] t4;
        logic signed [7:0] t8;
        tile_if.ena    = 1'b1;
        tile_if.uio_in = {1'b1, 1'b0, addr};
        tile_if.ui_in  = data;
        if (addr < 6'd32) begin
            t4 = data[3:0];
            mw[addr[4:3]][addr[2:0]] = t4;
        end else if (addr < 6'd36) begin
            t8 = data;
            mb[addr[1:0]] = t8;
        end
        m_out[6] = 1'b0;
        exp_q.push_back(m_out);
        step(tag);
    endtask

    task automatic do_infer(input logic [7:0] x, input logic rb, input logic [1:0] a, input string tag);
        tile_if.ena    = 1'b1;
        tile_if.uio_in = {1'b0, rb, 4'b0000, a};
        tile_if.ui_in  = x;
        model_infer(x, rb, a);
        exp_q.push_back(m_out);
        step(tag);
    endtask

    task automatic do_idle(input logic [7:0] ui, input logic [7:0] uio, input string tag);
        tile_if.ena    = 1'b0;
        tile_if.uio_in = uio;
        tile_if.ui_in  = ui;
        exp_q.push_back(m_out);
        step(tag);
        tile_if.ena = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tile_if.ena    = 1'b1;
        tile_if.ui_in  = 8'h00;
        tile_if.uio_in = 8'h00;
        model_reset();

        // Reset held with the clock running.
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_uo_out", tile_if.uo_out, 8'h00);
        check_val("rst_uio_oe", tile_if.uio_oe, 8'h00);
        check_val("rst_uio_out", tile_if.uio_out, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        do_infer(8'hFF, 1'b0, 2'd0, "post_rst_infer");
        check_val("post_rst_const", last_out, 8'h40);

        // Single neuron fires.
        do_write(6'd0, 8'h03, "wr_w00");
        do_write(6'd32, 8'hFE, "wr_b0");
        do_infer(8'h01, 1'b0, 2'd0, "single_fire");
        check_val("single_fire_const", last_out, 8'hC1);

        // Negative sum loses argmax to zero sums.
        do_infer(8'h00, 1'b0, 2'd0, "neg_excl");
        check_val("neg_excl_const", last_out, 8'h50);

        // Tie between neurons 2 and 3.
        do_write(6'd34, 8'h05, "wr_b2");
        do_write(6'd35, 8'h05, "wr_b3");
        do_infer(8'h00, 1'b0, 2'd0, "tie");
        check_val("tie_const", last_out, 8'hEC);

        // Most negative sum for neuron 1.
        for (int i = 0; i < 8; i++) do_write(6'(8 + i), 8'h08, "wr_w1_min");
        do_write(6'd33, 8'h80, "wr_b1_min");
        do_infer(8'hFF, 1'b0, 2'd0, "sat_min");
        check_val("sat_min_const", last_out, 8'hED);
`ifdef NEURAL_NAV_READBACK_EN
        do_infer(8'hFF, 1'b1, 2'd1, "rb_sat_min");
        check_val("rb_sat_min_const", last_out, 8'h80);
        do_infer(8'hFF, 1'b0, 2'd0, "sat_min_again");
`else
        // rb_sel must be ignored in this build.
        do_infer(8'hFF, 1'b1, 2'd1, "rb_ignored");
        check_val("rb_ignored_const", last_out, 8'hED);
`endif

        // Write to an unmapped address: decision holds, valid drops.
        do_write(6'd48, 8'h7F, "wr_hole");
        check_val("wr_hole_const", last_out, 8'hAD);
        do_infer(8'hFF, 1'b0, 2'd0, "hole_no_effect");
        check_val("hole_no_effect_const", last_out, 8'hED);

        // Enable low: nothing moves, including attempted writes.
        do_idle(8'h00, 8'h80, "ena0_a");
        do_idle(8'h5A, 8'hA0, "ena0_b");
        do_idle(8'h01, 8'h00, "ena0_c");
        do_infer(8'h01, 1'b0, 2'd0, "ena0_params_kept");
        check_val("ena0_params_const", last_out, 8'hED);

        // Randomised mix of writes and inferences against the model.
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                do_write(6'($urandom_range(0, 63)), 8'($urandom), "rnd_write");
            end else begin
                do_infer(8'($urandom), 1'b0, 2'd0, "rnd_infer");
            end
        end

        // Asynchronous reset in the middle of a cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("mid_rst_uo_out", tile_if.uo_out, 8'h00);
        model_reset();
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        do_infer(8'hFF, 1'b0, 2'd0, "mid_rst_infer");
        check_val("mid_rst_const", last_out, 8'h40);

        check_val("end_uio_oe", tile_if.uio_oe, 8'h00);
        check_val("end_uio_out", tile_if.uio_out, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
